instr_word_encoder: RTL and testbench
=====================================

# instr_word_encoder

Sequential RISC-V instruction encoder and program loader for the single-cycle core's instruction memory. It is the inverse of the core's decode path: it accepts field-level instruction descriptions over a valid/ready handshake and packs them into 32-bit machine words. It checks that each request is legal for the subset the core's controller executes, then writes legal words to consecutive instruction-memory locations. It sits in the testbench/boot path, ahead of instruction memory, and is used to load programs.

## Interface
- DEPTH, 64, instruction-memory capacity in words; loader stops at DEPTH writes.
- ADDR_W, 32, width of the byte address driven to instruction memory.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: clear address/count/err, leave FULL.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept this cycle.
- op_class  in  3  0 R, 1 IMM, 2 LW, 3 SW, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI.
- func3  in  3  used for R/IMM/BRANCH only; hardware inserts the fixed func3 for the other classes.
- alt  in  1  R-type only: selects func7=0100000 (sub).
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  signed immediate (byte offset for B/J, full value for LUI).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written since reset/start.
- full  out  1  count == DEPTH.
- err  out  1  sticky illegal-request flag.

## Operation
- FSM states: IDLE, WRITE, FULL.
- IDLE: in_ready=1. If in_valid, capture the request and encode it.
  - Legal request: register the word and go to WRITE.
  - Illegal request: set err, drop the word, stay in IDLE.
- WRITE: mem_we=1 with mem_addr and mem_wdata stable, in_ready=0, for exactly one cycle. At the end of the cycle, mem_addr += 4 and count += 1. Next state is FULL if the new count == DEPTH, otherwise IDLE.
- FULL: in_ready=0 and mem_we=0. Only start or reset leaves this state.
- start: in any state, sets mem_addr=0, count=0, err=0 and goes to IDLE. The in-flight WRITE is suppressed. start has priority over in_valid in the same cycle.
- Encodings (opcode in [6:0]):
  - R: 0110011; func7 = alt ? 0100000 : 0.
  - IMM: 0010011.
  - LW: 0000011, func3=2.
  - SW: 0100011, func3=2.
  - BRANCH: 1100011.
  - JAL: 1101111.
  - JALR: 1100111, func3=0.
  - LUI: 0110111.
- Immediate packing follows the standard I/S/B/U/J formats:
  - I: imm[11:0] -> [31:20].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12|10:5] -> [31:25], imm[4:1|11] -> [11:7].
  - U: imm[31:12] -> [31:12].
  - J: imm[20|10:1|11|19:12] -> [31:12].
- Fields unused by a format are ignored, e.g. rs2 for I-type and rd for S/B.
- Illegal conditions (any one sets err):
  - R: func3 not in {0,2,3,4,6,7}, or alt=1 with func3≠0.
  - IMM: func3 not in {0,2,3,4,6,7}, or alt=1.
  - BRANCH: func3 not in {0,1,4,5}.
  - I/S range: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - LUI: imm[11:0] ≠ 0.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, state IDLE.
- Reset asserted mid-WRITE aborts the write immediately; mem_we drops asynchronously.
- Handshake: the transfer occurs on the edge where in_valid & in_ready are both 1. Requests are never lost or duplicated; in_valid held through in_ready=0 waits.
- Latency: accept at edge N; mem_we=1 during cycle N+1; in_ready returns to 1 in cycle N+2 (IDLE) unless full.
- Throughput: one word per 2 cycles.
- Illegal request: consumed in one cycle; err=1 from the next cycle; in_ready stays 1.
- full and in_ready are registered from state; full rises in the cycle after the DEPTH-th write.
- mem_addr wraps only via start; it never exceeds 4*(DEPTH-1) while mem_we=1.

## Test plan
- Reset then addi x1,x0,5 (op1,f3 0,rd1,imm5) -> mem_we one cycle, addr 0, data 0x00500093; count=1, addr becomes 4.
- Back-to-back, in_valid held high: sub x3,x1,x2 (op0,alt1), sw x2,8(x1), lui x5,0x12345000 -> 0x402081B3 @0, 0x0020A423 @4, 0x123452B7 @8. Writes are 2 cycles apart.
- beq x1,x2,-4 then jal x1,8 -> 0xFE208EE3, 0x008000EF at consecutive addresses.
- Illegal requests: branch func3=2; addi imm=0x800; jal imm=3 -> err=1 after the first, no mem_we for any, count unchanged. start then clears err.
- DEPTH=4: five legal requests -> 4 writes (addr 0..12), full=1, in_ready=0, fifth held. start -> full=0, fifth written at addr 0.
- rst_n low during WRITE -> mem_we=0 immediately, all outputs at reset values. start coincident with in_valid -> request not accepted.

Source files
------------

// File: rtl/instr_word_encoder_if.sv
// Request channel into the instruction encoder: a valid/ready handshake
// carrying one field-level instruction description per transfer.
interface instr_word_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_class;
  logic [2:0]  func3;
  logic        alt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output in_valid, op_class, func3, alt, rd, rs1, rs2, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_class, func3, alt, rd, rs1, rs2, imm,
    output in_ready
  );
endinterface

// File: rtl/instr_word_encoder.sv
// Field-level RISC-V instruction encoder and sequential program loader.
// Legal requests are packed into 32-bit words and written to consecutive
// instruction-memory locations. Illegal requests set a sticky err flag and
// are dropped.
module instr_word_encoder #(
  parameter  int DEPTH  = 64,
  parameter  int ADDR_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_word_encoder_if.slave   req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  err
);

  localparam logic [2:0] C_R = 3'd0, C_IMM = 3'd1, C_LW = 3'd2, C_SW = 3'd3,
                         C_BR = 3'd4, C_JAL = 3'd5, C_JALR = 3'd6, C_LUI = 3'd7;

  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  state_t state, state_nxt;

  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic        alu_f3_ok, br_f3_ok, i_rng_ok, b_rng_ok, j_rng_ok;

  // start wins over a same-cycle request, so in_ready is already low then
  assign accept = req.in_valid & req.in_ready;

  // Immediate range checks: the upper bits must be a pure sign extension
  assign i_rng_ok  = (&req.imm[31:11]) | ~(|req.imm[31:11]);
  assign b_rng_ok  = ((&req.imm[31:12]) | ~(|req.imm[31:12])) & ~req.imm[0];
  assign j_rng_ok  = ((&req.imm[31:20]) | ~(|req.imm[31:20])) & ~req.imm[0];
  // Shift func3 values (1, 5) are not executed by the core's ALU decode
  assign alu_f3_ok = (req.func3 != 3'd1) && (req.func3 != 3'd5);
  assign br_f3_ok  = (req.func3 == 3'd0) || (req.func3 == 3'd1) ||
                     (req.func3 == 3'd4) || (req.func3 == 3'd5);

  // Pack the request into its machine word and flag anything the core can't run
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (req.op_class)
      C_R: begin
        word    = {req.alt ? 7'b0100000 : 7'b0000000, req.rs2, req.rs1,
                   req.func3, req.rd, OP_R};
        illegal = !alu_f3_ok || (req.alt && req.func3 != 3'd0);
      end
      C_IMM: begin
        word    = {req.imm[11:0], req.rs1, req.func3, req.rd, OP_IMM};
        illegal = !alu_f3_ok || req.alt || !i_rng_ok;
      end
      C_LW: begin
        word    = {req.imm[11:0], req.rs1, 3'b010, req.rd, OP_LW};
        illegal = !i_rng_ok;
      end
      C_SW: begin
        word    = {req.imm[11:5], req.rs2, req.rs1, 3'b010, req.imm[4:0], OP_SW};
        illegal = !i_rng_ok;
      end
      C_BR: begin
        word    = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.func3,
                   req.imm[4:1], req.imm[11], OP_BR};
        illegal = !br_f3_ok || !b_rng_ok;
      end
      C_JAL: begin
        word    = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                   req.rd, OP_JAL};
        illegal = !j_rng_ok;
      end
      C_JALR: begin
        word    = {req.imm[11:0], req.rs1, 3'b000, req.rd, OP_JALR};
        illegal = !i_rng_ok;
      end
      C_LUI: begin
        word    = {req.imm[31:12], req.rd, OP_LUI};
        illegal = (req.imm[11:0] != 12'h0);
      end
      default: begin
        word    = 32'h0;
        illegal = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one write per accepted legal word, park in FULL at DEPTH
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept && !illegal) state_nxt = S_WRITE;
        S_WRITE: state_nxt = (count == CNT_W'(DEPTH - 1)) ? S_FULL : S_IDLE;
        S_FULL:  state_nxt = S_FULL;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; start suppresses both the accept and the write
  always_comb begin
    req.in_ready = 1'b0;
    mem_we       = 1'b0;
    full         = 1'b0;
    case (state)
      S_IDLE:  req.in_ready = !start;
      S_WRITE: mem_we       = !start;
      S_FULL:  full         = 1'b1;
      default: ;
    endcase
  end

  // Datapath: captured word, write address, word count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else if (start) begin
      mem_addr  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && illegal)  err       <= 1'b1;
      if (accept && !illegal) mem_wdata <= word;
      if (state == S_WRITE) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        count    <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder (DEPTH=4) with hand-computed words.
module tb_instr_word_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        full;
  logic        err;

  instr_word_encoder_if bus ();

  instr_word_encoder #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req       (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write, sampled mid-cycle
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      w.a = mem_addr;
      w.d = mem_wdata;
      w.c = cyc;
      wq.push_back(w);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wq.size()) begin
      chk({tag, "_addr"}, wq[idx].a, a);
      chk({tag, "_data"}, wq[idx].d, d);
    end else begin
      chk({tag, "_missing"}, wq.size(), idx + 1);
    end
  endtask

  // Present one request from a negedge; return at the negedge after acceptance
  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic alt_i,
                      input logic [4:0] rd_i, input logic [4:0] rs1_i,
                      input logic [4:0] rs2_i, input logic [31:0] imm_i);
    bit rdy;
    int n;
    rdy = 1'b0;
    n   = 0;
    bus.op_class = op;
    bus.func3    = f3;
    bus.alt      = alt_i;
    bus.rd       = rd_i;
    bus.rs1      = rs1_i;
    bus.rs2      = rs2_i;
    bus.imm      = imm_i;
    bus.in_valid = 1'b1;
    while (!rdy && n < 20) begin
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] addi_word(input int r, input int v);
    return (32'(v) << 20) | (32'(r) << 7) | 32'h13;
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.op_class = '0;
    bus.func3    = '0;
    bus.alt      = 1'b0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;

    // Reset values
    #3;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5: one-cycle write at 0, then address advances
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_we", mem_we, 1);
    chk("addi_addr", mem_addr, 0);
    chk("addi_data", mem_wdata, 32'h00500093);
    chk("addi_busy", bus.in_ready, 0);
    idle(1);
    chk("addi_we_drop", mem_we, 0);
    chk("addi_ready_back", bus.in_ready, 1);
    chk("addi_count", count, 1);
    chk("addi_next_addr", mem_addr, 4);

    // Back-to-back sub / sw / lui with in_valid held high
    pulse_start();
    wq.delete();
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    idle(3);
    chk("b2b_nwr", wq.size(), 3);
    chk_wr("b2b_sub", 0, 32'd0, 32'h402081B3);
    chk_wr("b2b_sw", 1, 32'd4, 32'h0020A423);
    chk_wr("b2b_lui", 2, 32'd8, 32'h123452B7);
    if (wq.size() == 3) begin
      chk("b2b_gap01", wq[1].c - wq[0].c, 2);
      chk("b2b_gap12", wq[2].c - wq[1].c, 2);
    end
    chk("b2b_count", count, 3);

    // beq x1,x2,-4 then jal x1,8
    pulse_start();
    wq.delete();
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    idle(3);
    chk("bj_nwr", wq.size(), 2);
    chk_wr("bj_beq", 0, 32'd0, 32'hFE208EE3);
    chk_wr("bj_jal", 1, 32'd4, 32'h008000EF);

    // Illegal requests: no writes, sticky err, start clears it
    pulse_start();
    wq.delete();
    send(3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("ill_err_first", err, 1);
    chk("ill_ready", bus.in_ready, 1);
    chk("ill_we", mem_we, 0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3);
    idle(3);
    chk("ill_nwr", wq.size(), 0);
    chk("ill_count", count, 0);
    chk("ill_err_sticky", err, 1);
    pulse_start();
    chk("ill_err_clr", err, 0);

    // Fill to DEPTH; fifth request waits until start
    wq.delete();
    for (int i = 1; i <= 4; i++) send(3'd1, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i));
    bus.op_class = 3'd1;
    bus.func3    = 3'd0;
    bus.alt      = 1'b0;
    bus.rd       = 5'd5;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd0;
    bus.imm      = 32'd5;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_ready", bus.in_ready, 0);
    chk("full_count", count, 4);
    chk("full_nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr("full_wr", i, 32'(4 * i), addi_word(i + 1, i + 1));
    pulse_start();
    chk("restart_full", full, 0);
    chk("restart_count", count, 0);
    send(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5);
    chk("restart_we", mem_we, 1);
    chk("restart_addr", mem_addr, 0);
    chk("restart_data", mem_wdata, addi_word(5, 5));
    idle(2);
    chk("restart_nwr", wq.size(), 5);
    chk("restart_count1", count, 1);

    // Reset in the middle of a write
    send(3'd1, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd6);
    bus.in_valid = 1'b0;
    chk("rstw_we_before", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_we", mem_we, 0);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_data", mem_wdata, 0);
    chk("rstw_count", count, 0);
    chk("rstw_ready", bus.in_ready, 1);
    chk("rstw_full", full, 0);
    chk("rstw_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start coincident with in_valid: request is not taken
    wq.delete();
    start        = 1'b1;
    bus.op_class = 3'd1;
    bus.func3    = 3'd0;
    bus.rd       = 5'd7;
    bus.imm      = 32'd7;
    bus.in_valid = 1'b1;
    #1;
    chk("stv_ready", bus.in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    idle(3);
    chk("stv_nwr", wq.size(), 0);
    chk("stv_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
